// File: rtl/memory_pkg.sv
// Shared definitions for the load/store memory stage: funct3 access codes,
// mselector bit positions, FSM state encoding and store-lane helpers.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int MSEL_LOAD_BIT  = 1;
  localparam int MSEL_STORE_BIT = 0;

  // Unrecognised funct3 codes fall back to a full-word access.
  function automatic size_t load_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SIZE_B;
      F3_H, F3_HU: return SIZE_H;
      default:     return SIZE_W;
    endcase
  endfunction

  function automatic size_t store_size(input logic [2:0] f3);
    case (f3)
      F3_B:    return SIZE_B;
      F3_H:    return SIZE_H;
      default: return SIZE_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SIZE_H:  return lo[0];
      SIZE_W:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(input size_t sz, input logic [1:0] lo);
    case (sz)
      SIZE_B:  return 4'b0001 << lo;
      SIZE_H:  return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] sd);
    case (sz)
      SIZE_B:  return {4{sd[7:0]}};
      SIZE_H:  return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

endpackage

// File: rtl/memory_load_extend.sv
// Combinational load lane select with sign/zero extension (little-endian).
module load_extend
  import memory_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*lane +: 8];
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Load/store memory stage: accepts one request in IDLE, drives the memory port and
// pulses done. Optional misaligned-access trap enabled by MEMORY_MISALIGN_TRAP_EN.
module memory
  import memory_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_WIDTH  = 17
) (
  input  logic                  clk,
  input  logic                  rstn,
`ifdef MEMORY_MISALIGN_TRAP_EN
  output logic                  misalign,
`endif
  input  logic                  enable,
  output logic                  done,
  input  logic [1:0]            mselector,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           sdata,
  input  logic [3:0]            in_wselector,
  input  logic [31:0]           in_pc,
  input  logic [31:0]           in_data,
  input  logic [4:0]            in_rd,
  output logic [3:0]            wselector,
  output logic [31:0]           pc,
  output logic [31:0]           data,
  output logic [4:0]            rd,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY - 1);

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  mem_en_q, mem_en_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            wselector_q, wselector_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           data_q, data_d;
  logic [4:0]            rd_q, rd_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            lane_q, lane_d;
  logic                  is_load_q, is_load_d;
  logic                  bypass_q, bypass_d;
  logic                  misalign_q, misalign_d;

  logic                  req_load, req_store, req_misal, req_bypass;
  size_t                 req_size;
  logic [31:0]           load_data;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^addr;

  assign req_load   = mselector[MSEL_LOAD_BIT];
  assign req_store  = mselector[MSEL_STORE_BIT] & ~req_load;
  assign req_size   = req_load ? load_size(funct3) : store_size(funct3);
`ifdef MEMORY_MISALIGN_TRAP_EN
  assign req_misal  = (req_load | req_store) & is_misaligned(req_size, addr[1:0]);
`else
  assign req_misal  = 1'b0;
`endif
  // A bypassed request never touches the memory port and completes in ACCESS.
  assign req_bypass = ~(req_load | req_store) | req_misal;

  load_extend u_load_extend (
    .rdata  (mem_rdata),
    .funct3 (funct3_q),
    .lane   (lane_q),
    .data   (load_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 4'b0000;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wselector_d = wselector_q;
    pc_d        = pc_q;
    data_d      = data_q;
    rd_d        = rd_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    is_load_d   = is_load_q;
    bypass_d    = bypass_q;
    misalign_d  = misalign_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d     = ACCESS;
          funct3_d    = funct3;
          lane_d      = addr[1:0];
          is_load_d   = req_load;
          bypass_d    = req_bypass;
          misalign_d  = req_misal;
          pc_d        = in_pc;
          rd_d        = in_rd;
          data_d      = in_data;
          wselector_d = req_misal ? 4'b0000 : in_wselector;
          mem_addr_d  = addr[ADDR_WIDTH+1:2];
          done_d      = req_bypass;
          mem_en_d    = ~req_bypass;
          if (req_store && !req_bypass) begin
            mem_we_d    = store_strobe(req_size, addr[1:0]);
            mem_wdata_d = store_wdata(req_size, sdata);
          end
        end
      end
      ACCESS: begin
        if (bypass_q) begin
          state_d = IDLE;
        end else if (is_load_q) begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end else begin
          done_d  = 1'b1;
          state_d = FINISH;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          data_d  = load_data;
          done_d  = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      wselector_q <= 4'b0000;
      pc_q        <= 32'd0;
      data_q      <= 32'd0;
      rd_q        <= 5'd0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
      is_load_q   <= 1'b0;
      bypass_q    <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wselector_q <= wselector_d;
      pc_q        <= pc_d;
      data_q      <= data_d;
      rd_q        <= rd_d;
      funct3_q    <= funct3_d;
      lane_q      <= lane_d;
      is_load_q   <= is_load_d;
      bypass_q    <= bypass_d;
      misalign_q  <= misalign_d;
    end
  end

  assign done      = done_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wselector = wselector_q;
  assign pc        = pc_q;
  assign data      = data_q;
  assign rd        = rd_q;
`ifdef MEMORY_MISALIGN_TRAP_EN
  assign misalign  = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_memory.sv
// Scoreboard bench for the memory stage: a byte-array reference model predicts
// responses and memory-port activity; monitors compare them as the DUT presents them.
module tb_memory;

  localparam int MEM_LATENCY = 2;
  localparam int ADDR_WIDTH  = 17;

  logic                  clk, rstn, enable, done;
  logic [1:0]            mselector;
  logic [2:0]            funct3;
  logic [31:0]           addr, sdata, in_pc, in_data, pc, data, mem_wdata, mem_rdata;
  logic [3:0]            in_wselector, wselector, mem_we;
  logic [4:0]            in_rd, rd;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
`ifdef MEMORY_MISALIGN_TRAP_EN
  logic                  misalign;
`endif

  memory #(.MEM_LATENCY(MEM_LATENCY), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
`ifdef MEMORY_MISALIGN_TRAP_EN
    .misalign     (misalign),
`endif
    .enable       (enable),
    .done         (done),
    .mselector    (mselector),
    .funct3       (funct3),
    .addr         (addr),
    .sdata        (sdata),
    .in_wselector (in_wselector),
    .in_pc        (in_pc),
    .in_data      (in_data),
    .in_rd        (in_rd),
    .wselector    (wselector),
    .pc           (pc),
    .data         (data),
    .rd           (rd),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    int          cycle;
    logic [31:0] data;
    bit          chk_data;
    logic [3:0]  wsel;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          mis;
  } resp_t;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            we;
    logic [31:0]           wdata;
    bit                    chk_wdata;
  } port_t;

  resp_t       resp_q[$];
  port_t       port_q[$];
  logic [7:0]  ref_bytes[64];
  logic [31:0] dev_mem[16];
  int          cycle;
  int          pass_cnt, check_cnt;
  bit          rd_pending;
  int          rd_count;
  logic [31:0] rd_word;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
  endtask

  task automatic flagFail(input string name);
    check_cnt++;
    $display("[TB] FAIL %s: event not expected or not seen (cycle %0d)", name, cycle);
  endtask

  // Memory device: writes strobed bytes, returns read data MEM_LATENCY cycles after mem_en.
  always @(posedge clk) begin
    logic [31:0] next_rd;
    int          idx;
    next_rd = $urandom;
    idx = int'(mem_addr) - 64;
    if (!rstn) begin
      rd_pending = 1'b0;
    end else begin
      if (rd_pending) begin
        rd_count = rd_count - 1;
        if (rd_count == 0) begin
          next_rd    = rd_word;
          rd_pending = 1'b0;
        end
      end
      if (mem_en && idx >= 0 && idx < 16) begin
        if (mem_we != 4'b0000) begin
          for (int b = 0; b < 4; b++)
            if (mem_we[b]) dev_mem[idx][8*b +: 8] = mem_wdata[8*b +: 8];
        end else if (MEM_LATENCY == 1) begin
          next_rd = dev_mem[idx];
        end else begin
          rd_pending = 1'b1;
          rd_count   = MEM_LATENCY - 1;
          rd_word    = dev_mem[idx];
        end
      end
    end
    mem_rdata <= next_rd;
  end

  // Response monitor.
  always @(negedge clk) begin
    resp_t e;
    if (rstn && done) begin
      if (resp_q.size() == 0) begin
        flagFail("unexpected_done");
      end else begin
        e = resp_q.pop_front();
        checkOutput("done_cycle", cycle, e.cycle);
        if (e.chk_data) checkOutput("data", data, e.data);
        checkOutput("wselector", {28'd0, wselector}, {28'd0, e.wsel});
        checkOutput("pc", pc, e.pc);
        checkOutput("rd", {27'd0, rd}, {27'd0, e.rd});
`ifdef MEMORY_MISALIGN_TRAP_EN
        checkOutput("misalign", {31'd0, misalign}, {31'd0, e.mis});
`endif
      end
    end
  end

  // Memory-port monitor.
  always @(negedge clk) begin
    port_t p;
    if (rstn) begin
      if (mem_en) begin
        if (port_q.size() == 0) begin
          flagFail("unexpected_mem_en");
        end else begin
          p = port_q.pop_front();
          checkOutput("mem_addr", 32'(mem_addr), 32'(p.addr));
          checkOutput("mem_we", {28'd0, mem_we}, {28'd0, p.we});
          if (p.chk_wdata) checkOutput("mem_wdata", mem_wdata, p.wdata);
        end
      end else begin
        checkOutput("idle_mem_we", {28'd0, mem_we}, 32'd0);
      end
    end
  end

  function automatic int loadSize(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic int storeSize(input logic [2:0] f3);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] loadValue(input logic [2:0] f3, input int base, input int sz);
    logic [31:0] w;
    w = 32'd0;
    for (int i = 0; i < sz; i++) w[8*i +: 8] = ref_bytes[base + i];
    if (f3 == 3'b000) w = {{24{w[7]}}, w[7:0]};
    if (f3 == 3'b001) w = {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  // Drives one request for a single cycle and records what the model expects of it.
  task automatic issue(input logic [1:0] msel, input logic [2:0] f3, input int off, input logic [31:0] sd);
    resp_t r;
    port_t p;
    bit    ld, st, mis;
    int    sz, base;
    @(negedge clk);
    enable = 1'b1; mselector = msel; funct3 = f3; addr = 32'h100 + off; sdata = sd;
    in_wselector = 4'($urandom); in_pc = $urandom; in_data = $urandom; in_rd = 5'($urandom);
    ld  = msel[1];
    st  = (msel == 2'b01);
    sz  = ld ? loadSize(f3) : storeSize(f3);
    mis = 1'b0;
`ifdef MEMORY_MISALIGN_TRAP_EN
    mis = (ld || st) && (off % sz != 0);
`endif
    r.mis = mis; r.wsel = mis ? 4'd0 : in_wselector; r.pc = in_pc; r.rd = in_rd;
    r.data = in_data; r.chk_data = 1'b1;
    if (!(ld || st) || mis) begin
      r.cycle = cycle + 1;
    end else begin
      base   = off - (off % sz);
      p.addr = ADDR_WIDTH'(addr >> 2);
      if (st) begin
        for (int i = 0; i < sz; i++) ref_bytes[base + i] = sd[8*i +: 8];
        p.we        = 4'((1 << sz) - 1) << (base % 4);
        p.wdata     = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
        p.chk_wdata = 1'b1;
        r.cycle     = cycle + 2;
        r.chk_data  = 1'b0;
      end else begin
        p.we        = 4'd0;
        p.wdata     = 32'd0;
        p.chk_wdata = 1'b0;
        r.cycle     = cycle + MEM_LATENCY + 2;
        r.data      = loadValue(f3, base, sz);
      end
      port_q.push_back(p);
    end
    resp_q.push_back(r);
  endtask

  task automatic waitDone(input bit hold);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < MEM_LATENCY + 8 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen   = 1'b1;
        enable = 1'b0;
      end else begin
        enable = hold; mselector = 2'($urandom); funct3 = 3'($urandom);
        addr = $urandom; sdata = $urandom; in_wselector = 4'($urandom);
        in_pc = $urandom; in_data = $urandom; in_rd = 5'($urandom);
      end
    end
    if (!seen) flagFail("done_timeout");
  endtask

  task automatic applyStimulus(input logic [1:0] msel, input logic [2:0] f3, input int off,
                               input logic [31:0] sd, input bit hold);
    issue(msel, f3, off, sd);
    waitDone(hold);
  endtask

  task automatic checkResetState();
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mem_en", {31'd0, mem_en}, 32'd0);
    checkOutput("rst_mem_we", {28'd0, mem_we}, 32'd0);
    checkOutput("rst_wselector", {28'd0, wselector}, 32'd0);
    checkOutput("rst_data", data, 32'd0);
    checkOutput("rst_pc", pc, 32'd0);
    checkOutput("rst_rd", {27'd0, rd}, 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
`ifdef MEMORY_MISALIGN_TRAP_EN
    checkOutput("rst_misalign", {31'd0, misalign}, 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pass_cnt = 0; check_cnt = 0; cycle = 0; rd_pending = 1'b0;
    rstn = 1'b0; enable = 1'b0; mselector = 2'd0; funct3 = 3'd0; addr = 32'd0; sdata = 32'd0;
    in_wselector = 4'd0; in_pc = 32'd0; in_data = 32'd0; in_rd = 5'd0;
    for (int i = 0; i < 64; i++) begin
      ref_bytes[i] = 8'($urandom);
      dev_mem[i / 4][8*(i % 4) +: 8] = ref_bytes[i];
    end
    #1;
    checkResetState();
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Directed: sw, lb sign extension, sh then lhu.
    applyStimulus(2'b01, 3'b010, 0, 32'hDEADBEEF, 1'b0);
    applyStimulus(2'b01, 3'b010, 0, 32'h80FFFFFF, 1'b0);
    applyStimulus(2'b10, 3'b000, 3, 32'd0, 1'b0);
    applyStimulus(2'b01, 3'b010, 0, 32'h00000000, 1'b0);
    applyStimulus(2'b01, 3'b001, 2, 32'h00001234, 1'b0);
    applyStimulus(2'b10, 3'b101, 2, 32'd0, 1'b0);

    // Enable held high while busy; mselector=11 is a load only.
    applyStimulus(2'b10, 3'b010, 4, 32'd0, 1'b1);
    applyStimulus(2'b11, 3'b000, 5, 32'hFFFFFFFF, 1'b1);
    applyStimulus(2'b00, 3'b010, 6, 32'd0, 1'b1);
    applyStimulus(2'b01, 3'b000, 7, 32'h000000A5, 1'b1);

    // Reset asserted while the load sits in WAIT.
    issue(2'b10, 3'b010, 8, 32'd0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    #1;
    rstn = 1'b0;
    resp_q.delete();
    port_q.delete();
    #1;
    checkResetState();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    applyStimulus(2'b10, 3'b010, 8, 32'd0, 1'b0);

`ifdef MEMORY_MISALIGN_TRAP_EN
    applyStimulus(2'b10, 3'b010, 2, 32'd0, 1'b0);
    applyStimulus(2'b01, 3'b001, 5, 32'h0000BEEF, 1'b0);
`endif

    for (int n = 0; n < 150; n++) begin
      applyStimulus(2'($urandom), 3'($urandom), int'($urandom_range(0, 63)), $urandom,
                    ($urandom_range(0, 3) == 0));
    end

    repeat (MEM_LATENCY + 5) @(negedge clk);
    checkOutput("resp_q_drained", resp_q.size(), 32'd0);
    checkOutput("port_q_drained", port_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
